// File: rtl/signed_alu_pkg.sv
// signed_alu_pkg: shared op encoding, flag positions and signed range helpers
package signed_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_MAC, OP_ACLR, OP_RSV6, OP_RSV7
  } alu_op_t;
  localparam int FLAG_LT  = 0;
  localparam int FLAG_GT  = 1;
  localparam int FLAG_EQ  = 2;
  localparam int FLAG_OVF = 3;
  localparam int FLAG_ERR = 4;
  // Helpers work on 64-bit signed values, so callers keep width+1 <= 64
  function automatic logic signed [63:0] lim_hi(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] lim_lo(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction
  function automatic logic ovf_signed(input logic signed [63:0] value, input int width);
    return value > lim_hi(width) || value < lim_lo(width);
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
    return value > lim_hi(width) ? lim_hi(width) : value < lim_lo(width) ? lim_lo(width) : value;
  endfunction
endpackage

// File: rtl/signed_sat_addsub.sv
// signed_sat_addsub: exact WIDTH+1 add/sub with overflow detect and optional saturation
module signed_sat_addsub import signed_alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  input  logic                    sat_en,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);
  logic signed [WIDTH:0] exact;
  assign exact = sub ? (WIDTH+1)'(a) - (WIDTH+1)'(b) : (WIDTH+1)'(a) + (WIDTH+1)'(b);
  assign ovf = ovf_signed(64'(exact), WIDTH);
  assign y = sat_en ? WIDTH'(sat_signed(64'(exact), WIDTH)) : exact[WIDTH-1:0];
endmodule

// File: rtl/signed_alu_pipe.sv
// signed_alu_pipe: two-stage valid/ready signed ALU with saturation, flags and MAC accumulator
module signed_alu_pipe import signed_alu_pkg::*; #(
  parameter  int WIDTH = 8,
  parameter  int GUARD = 8,
  localparam int RES_W = 2*WIDTH,
  localparam int ACC_W = 2*WIDTH + GUARD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic                    sat_en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [RES_W-1:0] result,
  output logic [4:0]              flags,
  output logic signed [ACC_W-1:0] acc
);
  logic                    advance;
  logic                    s1_valid, s1_sat;
  alu_op_t                 s1_op;
  logic signed [WIDTH-1:0] s1_a, s1_b, as_y;
  logic signed [RES_W-1:0] s1_prod, result_d;
  logic signed [ACC_W:0]   acc_exact;
  logic signed [ACC_W-1:0] acc_d;
  logic [4:0]              flags_d;
  logic                    as_ovf, is_addsub, is_cmp, is_mac;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_sat   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= alu_op_t'(op);
        s1_sat  <= sat_en;
        s1_a    <= a;
        s1_b    <= b;
        s1_prod <= RES_W'(a) * RES_W'(b);
      end
    end
  signed_sat_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(s1_a), .b(s1_b), .sub(s1_op == OP_SUB), .sat_en(s1_sat), .y(as_y), .ovf(as_ovf)
  );
  // One extra bit keeps the accumulate exact so overflow is a range test
  assign acc_exact = (ACC_W+1)'(acc) + (ACC_W+1)'(s1_prod);
  always_comb begin
    is_addsub = s1_op == OP_ADD || s1_op == OP_SUB;
    is_cmp    = s1_op == OP_CMP;
    is_mac    = s1_op == OP_MAC;
    result_d  = is_addsub ? RES_W'(as_y) : (s1_op == OP_MUL || is_mac) ? s1_prod : '0;
    acc_d     = is_mac ? (s1_sat ? ACC_W'(sat_signed(64'(acc_exact), ACC_W)) : acc_exact[ACC_W-1:0])
              : s1_op == OP_ACLR ? '0 : acc;
    flags_d           = '0;
    flags_d[FLAG_LT]  = is_cmp && s1_a < s1_b;
    flags_d[FLAG_GT]  = is_cmp && s1_a > s1_b;
    flags_d[FLAG_EQ]  = is_cmp && s1_a == s1_b;
    flags_d[FLAG_OVF] = is_addsub ? as_ovf : is_mac && ovf_signed(64'(acc_exact), ACC_W);
    flags_d[FLAG_ERR] = s1_op inside {OP_RSV6, OP_RSV7};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= result_d;
        flags  <= flags_d;
        acc    <= acc_d;
      end
    end
endmodule
